// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and per-step byte-command builder for i2c_reg_ctrl.
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, ABORT, RESP} state_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_DEV_W, SEL_DEV_R, SEL_HI, SEL_LO, SEL_DATA} sel_t;
    typedef struct packed {
        logic start;
        logic wdata;
        logic rdata;
        logic stop;
        logic last;
        sel_t sel;
    } cmd_t;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ = 1'b1;
    // Narrow register addresses skip slot 1 (reg_hi) so both widths share one slot map.
    function automatic cmd_t step_cmd(input logic [2:0] step, input logic rw, input logic reg16);
        cmd_t c;
        logic [2:0] k;
        c = '0;
        k = (reg16 || step == 3'd0) ? step : step + 3'd1;
        case (k)
            3'd0: begin c.start = 1'b1; c.wdata = 1'b1; c.sel = SEL_DEV_W; end
            3'd1: begin c.wdata = 1'b1; c.sel = SEL_HI; end
            3'd2: begin c.wdata = 1'b1; c.sel = SEL_LO; end
            3'd3: if (rw == RW_WRITE) begin
                c.wdata = 1'b1; c.stop = 1'b1; c.last = 1'b1; c.sel = SEL_DATA;
            end else begin
                c.start = 1'b1; c.wdata = 1'b1; c.sel = SEL_DEV_R;
            end
            3'd4: begin c.rdata = 1'b1; c.stop = 1'b1; c.last = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: splits one register read/write request into byte-engine commands,
// checks ACKs, aborts with STOP on NACK, and returns one response per request.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter bit          REG_ADDR_16 = 1'b0,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rw,
    input  logic [6:0]  i_dev_addr,
    input  logic [15:0] i_reg_addr,
    input  logic [7:0]  i_req_wdata,
    output logic        o_resp_valid,
    output logic [7:0]  o_resp_rdata,
    output logic        o_resp_nack,
    output logic        o_resp_timeout,
    output logic        o_cmd_start,
    output logic        o_cmd_wdata,
    output logic        o_cmd_rdata,
    output logic        o_cmd_stop,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic [7:0]  o_wdata,
    input  logic        i_rvalid,
    output logic        o_rready,
    input  logic [7:0]  i_rdata,
    input  logic        i_busy,
    input  logic        i_done,
    input  logic        i_ack
);
    state_t      state, state_n;
    cmd_t        cmd;
    logic        rw_q, nack_q, to_q, abort_sent, rready_q, waiting, tmo, unused;
    logic [6:0]  dev_q;
    logic [15:0] reg_q;
    logic [7:0]  wd_q, rd_q, wbyte;
    logic [2:0]  step;
    logic [31:0] cnt;
    assign unused = i_busy;
    assign cmd = step_cmd(step, rw_q, REG_ADDR_16);
    assign waiting = state == WAIT || (state == ABORT && abort_sent);
    assign tmo = TIMEOUT_CYC != 32'd0 && cnt == TIMEOUT_CYC - 32'd1;
    assign wbyte = cmd.sel == SEL_DEV_W ? {dev_q, 1'b0} :
                   cmd.sel == SEL_DEV_R ? {dev_q, 1'b1} :
                   cmd.sel == SEL_HI    ? reg_q[15:8] :
                   cmd.sel == SEL_LO    ? reg_q[7:0] :
                   cmd.sel == SEL_DATA  ? wd_q : 8'h00;
    assign o_req_ready = state == IDLE;
    assign o_resp_valid = state == RESP;
    assign o_resp_nack = o_resp_valid && nack_q;
    assign o_resp_timeout = o_resp_valid && to_q;
    assign o_resp_rdata = (o_resp_valid && rw_q == RW_READ && !nack_q && !to_q) ? rd_q : 8'h00;
    assign o_rready = rready_q;
    always_comb begin
        state_n = state;
        o_wvalid = 1'b0;
        o_cmd_start = 1'b0;
        o_cmd_wdata = 1'b0;
        o_cmd_rdata = 1'b0;
        o_cmd_stop = 1'b0;
        o_wdata = 8'h00;
        case (state)
            IDLE: state_n = i_req_valid ? ISSUE : IDLE;
            ISSUE: begin
                o_wvalid = 1'b1;
                o_cmd_start = cmd.start;
                o_cmd_wdata = cmd.wdata;
                o_cmd_rdata = cmd.rdata;
                o_cmd_stop = cmd.stop;
                o_wdata = wbyte;
                state_n = i_wready ? WAIT : ISSUE;
            end
            WAIT: state_n = i_done ? ((cmd.wdata && !i_ack) ? ABORT : cmd.last ? RESP : NEXT) :
                            tmo ? RESP : WAIT;
            NEXT: state_n = ISSUE;
            ABORT: begin
                o_wvalid = !abort_sent;
                o_cmd_stop = !abort_sent;
                state_n = (abort_sent && (i_done || tmo)) ? RESP : ABORT;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rw_q <= 1'b0;
            dev_q <= '0;
            reg_q <= '0;
            wd_q <= '0;
            rd_q <= '0;
            step <= '0;
            cnt <= '0;
            nack_q <= 1'b0;
            to_q <= 1'b0;
            abort_sent <= 1'b0;
            rready_q <= 1'b0;
        end else begin
            state <= state_n;
            rready_q <= 1'b1;
            cnt <= waiting ? cnt + 32'd1 : '0;
            abort_sent <= state == ABORT && (abort_sent || i_wready);
            if (state == IDLE && i_req_valid) begin
                rw_q <= i_req_rw;
                dev_q <= i_dev_addr;
                reg_q <= i_reg_addr;
                wd_q <= i_req_wdata;
                rd_q <= '0;
                step <= '0;
                nack_q <= 1'b0;
                to_q <= 1'b0;
            end
            if (state == NEXT) step <= step + 3'd1;
            if (state == WAIT && i_done && cmd.wdata && !i_ack) nack_q <= 1'b1;
            if (waiting && !i_done && tmo) to_q <= 1'b1;
            if (state == WAIT && cmd.rdata && i_rvalid) rd_q <= i_rdata;
        end
    end
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: table-driven requests against 8-bit and 16-bit register-address
// instances, with a behavioural byte engine and command/response scoreboards.
module tb_i2c_reg_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic i_req_valid, i_req_rw, i_wready, i_rvalid, i_busy, i_done, i_ack;
    logic [6:0] i_dev_addr;
    logic [15:0] i_reg_addr;
    logic [7:0] i_req_wdata, i_rdata;
    logic [1:0] req_ready, resp_valid, resp_nack, resp_to, cs, cw, cr, cp, wvalid, rready;
    logic [7:0] resp_rdata [2];
    logic [7:0] wdata [2];
    logic m_req_ready, m_resp_valid, m_resp_nack, m_resp_to, m_cs, m_cw, m_cr, m_cp, m_wvalid, m_rready;
    logic [7:0] m_resp_rdata, m_wdata;
    int checks = 0, failures = 0, cyc = 0, resp_seen = 0, resp_cyc = 0, hs_cyc = 0, byte_idx = 0;
    int k_nack_at = 99, k_wr_delay = 0;
    logic k_early = 1'b0, k_no_done = 1'b0;
    logic [7:0] k_ret = 8'h00;

    typedef struct { logic s; logic w; logic r; logic p; logic [7:0] d; } cmd_e;
    typedef struct { logic n; logic t; logic [7:0] d; } resp_e;
    typedef struct {
        logic wide; logic rw; logic [6:0] dev; logic [15:0] rg; logic [7:0] wd; logic [7:0] ret;
        int nack_at; int wr_delay; logic early; logic exp_nack; logic [7:0] exp_rdata;
    } vec_t;
    cmd_e exp_cmd[$];
    resp_e exp_resp[$];
    vec_t vecs [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_reg_ctrl #(.REG_ADDR_16(1'b0), .TIMEOUT_CYC(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid && !sel), .o_req_ready(req_ready[0]),
        .i_req_rw(i_req_rw), .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(resp_valid[0]), .o_resp_rdata(resp_rdata[0]), .o_resp_nack(resp_nack[0]),
        .o_resp_timeout(resp_to[0]), .o_cmd_start(cs[0]), .o_cmd_wdata(cw[0]), .o_cmd_rdata(cr[0]),
        .o_cmd_stop(cp[0]), .o_wvalid(wvalid[0]), .i_wready(i_wready), .o_wdata(wdata[0]),
        .i_rvalid(i_rvalid), .o_rready(rready[0]), .i_rdata(i_rdata), .i_busy(i_busy),
        .i_done(i_done), .i_ack(i_ack));
    i2c_reg_ctrl #(.REG_ADDR_16(1'b1), .TIMEOUT_CYC(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid && sel), .o_req_ready(req_ready[1]),
        .i_req_rw(i_req_rw), .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(resp_valid[1]), .o_resp_rdata(resp_rdata[1]), .o_resp_nack(resp_nack[1]),
        .o_resp_timeout(resp_to[1]), .o_cmd_start(cs[1]), .o_cmd_wdata(cw[1]), .o_cmd_rdata(cr[1]),
        .o_cmd_stop(cp[1]), .o_wvalid(wvalid[1]), .i_wready(i_wready), .o_wdata(wdata[1]),
        .i_rvalid(i_rvalid), .o_rready(rready[1]), .i_rdata(i_rdata), .i_busy(i_busy),
        .i_done(i_done), .i_ack(i_ack));

    assign m_req_ready = req_ready[sel];
    assign m_resp_valid = resp_valid[sel];
    assign m_resp_nack = resp_nack[sel];
    assign m_resp_to = resp_to[sel];
    assign m_resp_rdata = resp_rdata[sel];
    assign m_cs = cs[sel];
    assign m_cw = cw[sel];
    assign m_cr = cr[sel];
    assign m_cp = cp[sel];
    assign m_wvalid = wvalid[sel];
    assign m_wdata = wdata[sel];
    assign m_rready = rready[sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] cur_cmd();
        return {m_cs, m_cw, m_cr, m_cp, m_wdata};
    endfunction

    function automatic logic [25:0] all_outs();
        return {m_req_ready, m_resp_valid, m_resp_nack, m_resp_to, m_resp_rdata, m_wvalid,
                m_cs, m_cw, m_cr, m_cp, m_wdata, m_rready};
    endfunction

    // Behavioural byte engine: takes each command, checks it against the scoreboard, answers.
    initial begin
        logic [11:0] first;
        logic stable, rd, stop_only;
        cmd_e e;
        i_wready = 1'b0; i_done = 1'b0; i_ack = 1'b0; i_rvalid = 1'b0; i_rdata = 8'h00; i_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && m_wvalid) begin
                first = cur_cmd();
                stable = 1'b1;
                for (int i = 0; i < k_wr_delay; i++) begin
                    @(negedge clk);
                    if (cur_cmd() !== first || m_wvalid !== 1'b1) stable = 1'b0;
                end
                if (k_wr_delay > 0) chk("issue_hold", {31'd0, stable}, 32'd1);
                hs_cyc = cyc + 1;
                if (exp_cmd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected: got %0h expected none", first);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd", {20'd0, first}, {20'd0, e.s, e.w, e.r, e.p, e.d});
                end
                rd = first[9];
                stop_only = first[8] && !first[10] && !first[9];
                i_busy = 1'b1;
                i_wready = 1'b1;
                @(negedge clk);
                i_wready = 1'b0;
                if (!k_no_done) begin
                    repeat (2) @(negedge clk);
                    if (rd) begin
                        i_rvalid = 1'b1;
                        i_rdata = k_ret;
                        if (k_early) begin
                            @(negedge clk);
                            i_rvalid = 1'b0;
                            i_rdata = ~k_ret;
                        end
                    end
                    i_ack = !rd && !stop_only && byte_idx != k_nack_at;
                    i_done = 1'b1;
                    @(negedge clk);
                    i_done = 1'b0; i_rvalid = 1'b0; i_ack = 1'b0; i_busy = 1'b0;
                end
                byte_idx++;
            end
        end
    end

    initial begin
        resp_e r;
        forever begin
            @(negedge clk);
            if (rst_n && m_resp_valid) begin
                resp_seen++;
                resp_cyc = cyc;
                if (exp_resp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected: got nack=%0b to=%0b rdata=%0h expected none",
                             m_resp_nack, m_resp_to, m_resp_rdata);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp", {22'd0, m_resp_nack, m_resp_to, m_resp_rdata}, {22'd0, r.n, r.t, r.d});
                end
            end
        end
    end

    task automatic drive_req(input vec_t v);
        sel = v.wide;
        k_nack_at = v.nack_at;
        k_wr_delay = v.wr_delay;
        k_early = v.early;
        k_ret = v.ret;
        byte_idx = 0;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_rw = v.rw; i_dev_addr = v.dev; i_reg_addr = v.rg; i_req_wdata = v.wd;
        chk("req_ready", {31'd0, m_req_ready}, 32'd1);
        @(negedge clk);
        i_req_valid = 1'b0; i_dev_addr = ~v.dev; i_reg_addr = ~v.rg; i_req_wdata = ~v.wd; i_req_rw = ~v.rw;
        chk("req_taken", {31'd0, m_req_ready}, 32'd0);
    endtask

    task automatic wait_resp(input int start);
        for (int i = 0; i < 400 && resp_seen == start; i++) @(negedge clk);
        chk("resp_count", resp_seen - start, 32'd1);
        @(negedge clk);
        chk("resp_one_cycle", {30'd0, m_resp_valid, m_req_ready}, 32'd1);
        chk("cmds_left", exp_cmd.size(), 32'd0);
    endtask

    task automatic run(input vec_t v);
        cmd_e full[$];
        int start;
        full.push_back('{1'b1, 1'b1, 1'b0, 1'b0, {v.dev, 1'b0}});
        if (v.wide) full.push_back('{1'b0, 1'b1, 1'b0, 1'b0, v.rg[15:8]});
        full.push_back('{1'b0, 1'b1, 1'b0, 1'b0, v.rg[7:0]});
        if (!v.rw) full.push_back('{1'b0, 1'b1, 1'b0, 1'b1, v.wd});
        else begin
            full.push_back('{1'b1, 1'b1, 1'b0, 1'b0, {v.dev, 1'b1}});
            full.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00});
        end
        for (int i = 0; i < full.size() && i <= v.nack_at; i++) exp_cmd.push_back(full[i]);
        if (v.nack_at < full.size()) exp_cmd.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        exp_resp.push_back('{v.exp_nack, 1'b0, v.exp_rdata});
        start = resp_seen;
        drive_req(v);
        wait_resp(start);
    endtask

    initial begin
        vec_t v;
        int start;
        i_req_valid = 1'b0; i_req_rw = 1'b0; i_dev_addr = '0; i_reg_addr = '0; i_req_wdata = '0;
        //          wide rw  dev     reg       wd     ret    nack wr  early nack rdata
        vecs[0] = '{1'b0, 1'b0, 7'h50, 16'h0012, 8'hAA, 8'h00, 99, 0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 7'h50, 16'h1234, 8'h00, 8'h5A, 99, 0, 1'b0, 1'b0, 8'h5A};
        vecs[2] = '{1'b0, 1'b0, 7'h50, 16'h0012, 8'hAA, 8'h00, 0,  0, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 7'h50, 16'h1234, 8'h00, 8'h77, 0,  0, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 7'h3C, 16'hABCD, 8'h55, 8'h00, 99, 5, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 7'h7F, 16'h00FF, 8'h00, 8'hC3, 99, 0, 1'b1, 1'b0, 8'hC3};
        vecs[6] = '{1'b1, 1'b0, 7'h21, 16'hBEEF, 8'h66, 8'h00, 3,  0, 1'b0, 1'b1, 8'h00};
        vecs[7] = '{1'b1, 1'b1, 7'h21, 16'hBEEF, 8'h00, 8'h88, 3,  0, 1'b0, 1'b1, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 7'h11, 16'h0042, 8'h00, 8'h99, 1,  0, 1'b0, 1'b1, 8'h00};
        vecs[9] = '{1'b1, 1'b1, 7'h6A, 16'h8001, 8'h00, 8'h3C, 99, 2, 1'b1, 1'b0, 8'h3C};
        #1;
        chk("reset_outs", {6'd0, all_outs()}, {6'd0, 1'b1, 25'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rready", {31'd0, m_rready}, 32'd1);
        foreach (vecs[i]) run(vecs[i]);

        // Engine never finishes the first byte: timeout 16 cycles after handshake, no STOP.
        v = vecs[0];
        v.wide = 1'b1;
        k_no_done = 1'b1;
        exp_cmd.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'hA0});
        exp_resp.push_back('{1'b0, 1'b1, 8'h00});
        start = resp_seen;
        drive_req(v);
        wait_resp(start);
        chk("timeout_cycles", resp_cyc - hs_cyc, 32'd16);
        repeat (4) @(negedge clk);

        // Reset while waiting for i_done, then a fresh request must complete.
        v = vecs[0];
        exp_cmd.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'hA0});
        drive_req(v);
        for (int i = 0; i < 50 && exp_cmd.size() != 0; i++) @(negedge clk);
        chk("reset_pre_cmd", exp_cmd.size(), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_outs", {6'd0, all_outs()}, {6'd0, 1'b1, 25'd0});
        exp_cmd.delete();
        exp_resp.delete();
        @(negedge clk);
        k_no_done = 1'b0;
        i_busy = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run(vecs[0]);
        run(vecs[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
